// File: rtl/dmem_pkg.sv
// Shared types and byte-lane helpers for the byte-addressable data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Byte-lane enables for an access of the given size starting at offset.
  function automatic logic [7:0] byte_mask(size_e size, logic [2:0] offset);
    logic [7:0] m;
    case (size)
      SZ_BYTE: m = 8'h01;
      SZ_HALF: m = 8'h03;
      SZ_WORD: m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << offset;
  endfunction

  // Offset bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(size_e size);
    logic [2:0] m;
    case (size)
      SZ_BYTE: m = 3'b000;
      SZ_HALF: m = 3'b001;
      SZ_WORD: m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/byte_data_memory_if.sv
// Request/response bus of the data memory plus the clear-sweep control.
interface byte_data_memory_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
);
  localparam int ADDR_W = $clog2(DEPTH * DATA_W / 8);

  // Handshake: a request transfers on a rising edge where ReqValid && ReqReady;
  // ReqReady never depends on ReqValid. Each transfer yields exactly one
  // RspValid pulse on the following cycle, and responses cannot be stalled.
  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic [1:0]        ReqSize;
  logic              ReqUnsigned;
  logic [ADDR_W-1:0] ReqAddr;
  logic [DATA_W-1:0] ReqWData;
  logic              RspValid;
  logic [DATA_W-1:0] RspData;
  logic              RspFault;
  logic              Clear;
  logic              Busy;

  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqUnsigned, ReqAddr, ReqWData, Clear,
    input  ReqReady, RspValid, RspData, RspFault, Busy
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqUnsigned, ReqAddr, ReqWData, Clear,
    output ReqReady, RspValid, RspData, RspFault, Busy
  );
endinterface

// File: rtl/dmem_load_align.sv
// Moves the addressed lanes of a storage word down to bit 0 and extends them.
module dmem_load_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]            word,
  input  logic [$clog2(DATA_W/8)-1:0]  offset,
  input  size_e                        size,
  input  logic                         is_unsigned,
  output logic [DATA_W-1:0]            data
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] top_bit;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    case (size)
      SZ_BYTE: mask = {DATA_W{1'b1}} >> (DATA_W - 8);
      SZ_HALF: mask = {DATA_W{1'b1}} >> (DATA_W - 16);
      SZ_WORD: mask = {DATA_W{1'b1}} >> (DATA_W - 32);
      default: mask = {DATA_W{1'b1}};
    endcase
    // The sign bit is the most significant bit kept by the mask.
    top_bit = mask & ~(mask >> 1);
    data    = shifted & mask;
    if (!is_unsigned && |(shifted & top_bit)) begin
      data = data | ~mask;
    end
  end

endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressable data memory: lane-enabled stores, aligned/extended loads,
// misalignment faults, one-cycle registered response and a zeroing sweep.
module byte_data_memory
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic                Clock,
  input  logic                R,
  byte_data_memory_if.slave   bus,
  output state_e              dbg_state
);

  localparam int NBYTES = DATA_W / 8;
  localparam int OFF_W  = $clog2(NBYTES);
  localparam int ADDR_W = $clog2(DEPTH * NBYTES);
  localparam int IDX_W  = $clog2(DEPTH);

  state_e            state, state_next;
  logic [IDX_W-1:0]  clr_idx, clr_idx_next;
  logic [DATA_W-1:0] mem [DEPTH];

  size_e             req_size;
  logic [OFF_W-1:0]  req_off;
  logic [2:0]        off3;
  logic [IDX_W-1:0]  req_idx;
  logic              req_ready;
  logic              accept;
  logic              fault;
  logic              do_store;
  logic [NBYTES-1:0] be;
  logic [DATA_W-1:0] wdata_sh;
  logic [DATA_W-1:0] load_data;

  logic              rsp_valid;
  logic              rsp_fault;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;

  assign req_size = size_e'(bus.ReqSize);
  assign req_off  = bus.ReqAddr[OFF_W-1:0];
  assign off3     = 3'(req_off);
  assign req_idx  = bus.ReqAddr[ADDR_W-1:OFF_W];

  // Dword accesses only exist when the storage word is 64 bits wide.
  assign fault    = (|(off3 & align_mask(req_size))) ||
                    ((req_size == SZ_DWORD) && (DATA_W != 64));
  assign be       = NBYTES'(byte_mask(req_size, off3));
  assign wdata_sh = bus.ReqWData << {req_off, 3'b000};

  assign req_ready = (state == IDLE) && !bus.Clear;
  assign accept    = bus.ReqValid && req_ready;
  assign do_store  = accept && bus.ReqWrite && !fault;

  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    case (state)
      IDLE: begin
        if (bus.Clear) state_next = CLEAR;
      end
      CLEAR: begin
        if (clr_idx == IDX_W'(DEPTH - 1)) begin
          state_next   = IDLE;
          clr_idx_next = '0;
        end else begin
          clr_idx_next = clr_idx + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge R) begin
    if (!R) begin
      state   <= IDLE;
      clr_idx <= '0;
    end else begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
    end
  end

  // The sweep and stores never coincide: ReqReady is low throughout CLEAR.
  always_ff @(posedge Clock or negedge R) begin
    if (!R) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (do_store) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (be[b]) mem[req_idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
      end
    end
  end

  dmem_load_align #(.DATA_W(DATA_W)) u_align (
    .word        (mem[req_idx]),
    .offset      (req_off),
    .size        (req_size),
    .is_unsigned (bus.ReqUnsigned),
    .data        (load_data)
  );

  always_ff @(posedge Clock or negedge R) begin
    if (!R) begin
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= accept;
      rsp_fault <= accept && fault;
      rsp_data  <= (accept && !bus.ReqWrite && !fault) ? load_data : '0;
      busy      <= (state_next == CLEAR);
    end
  end

  assign bus.ReqReady = req_ready;
  assign bus.RspValid = rsp_valid;
  assign bus.RspFault = rsp_fault;
  assign bus.RspData  = rsp_data;
  assign bus.Busy     = busy;
  assign dbg_state    = state;

endmodule

// File: tb/tb_byte_data_memory.sv
// Self-checking bench for byte_data_memory against a byte-array reference model.
module tb_byte_data_memory;
  import dmem_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int NB     = DEPTH * DATA_W / 8;
  localparam int ADDR_W = $clog2(NB);

  logic   Clock = 1'b0;
  logic   R     = 1'b0;
  state_e dbg_state;

  byte_data_memory_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  byte_data_memory #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .Clock     (Clock),
    .R         (R),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // ---------------- reference model / scoreboard ----------------
  logic [7:0]        ref_mem [NB];
  logic [DATA_W-1:0] exp_q[$];
  logic              exp_fault_q[$];

  task automatic model_req(input logic w, input logic [1:0] sz, input logic uns,
                           input logic [ADDR_W-1:0] a, input logic [31:0] wd);
    int              nb;
    int              ai;
    logic            f;
    longint unsigned v;
    nb = 1 << sz;
    ai = int'(a);
    f  = ((ai % nb) != 0) || (sz == 2'd3);
    v  = 0;
    if (!f && w) begin
      for (int i = 0; i < nb; i++) ref_mem[ai + i] = wd[8*i +: 8];
    end else if (!f) begin
      for (int i = 0; i < nb; i++) v = v | (longint'(ref_mem[ai + i]) << (8 * i));
      if (!uns && ((v >> (8 * nb - 1)) & 1) == 1) v = v | ~((64'd1 << (8 * nb)) - 1);
    end
    exp_q.push_back(v[31:0]);
    exp_fault_q.push_back(f);
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge; returns at the falling edge where the
  // response of this request is visible.
  task automatic send(input logic w, input logic [1:0] sz, input logic uns,
                      input logic [ADDR_W-1:0] a, input logic [31:0] wd);
    int waited = 0;
    bus.ReqValid    = 1'b1;
    bus.ReqWrite    = w;
    bus.ReqSize     = sz;
    bus.ReqUnsigned = uns;
    bus.ReqAddr     = a;
    bus.ReqWData    = wd;
    #1;
    while (bus.ReqReady !== 1'b1 && waited < 100) begin
      @(negedge Clock); #1; waited++;
    end
    checks++;
    if (bus.ReqReady !== 1'b1) begin
      errors++;
      $display("FAIL req_ready: ReqReady=%b after %0d cycles, expected 1", bus.ReqReady, waited);
    end
    model_req(w, sz, uns, a, wd);
    @(posedge Clock);
    @(negedge Clock);
    bus.ReqValid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [DATA_W-1:0] ed;
    logic              ef;
    R = 1'b0;
    repeat (3) @(negedge Clock);
    #1;
    checks++;
    if (bus.RspValid !== 1'b0 || bus.RspData !== '0 || bus.RspFault !== 1'b0 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h fault=%b busy=%b, expected all 0",
               bus.RspValid, bus.RspData, bus.RspFault, bus.Busy);
    end
    @(negedge Clock);
    R = 1'b1;
    #1;
    checks++;
    if (bus.ReqReady !== 1'b1 || bus.Busy !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_idle: ready=%b busy=%b state=%0d, expected ready=1 busy=0 state=IDLE",
               bus.ReqReady, bus.Busy, dbg_state);
    end
    @(negedge Clock);
    send(1'b0, 2'd2, 1'b0, 7'h00, 32'h0);
    ed = exp_q.pop_front(); ef = exp_fault_q.pop_front();
    checks++;
    if (bus.RspValid !== 1'b1 || bus.RspData !== 32'h0 || bus.RspFault !== 1'b0 || ed !== 32'h0 || ef !== 1'b0) begin
      errors++;
      $display("FAIL reset_load: valid=%b data=%h fault=%b, expected valid=1 data=00000000 fault=0",
               bus.RspValid, bus.RspData, bus.RspFault);
    end
    @(negedge Clock);
    checks++;
    if (bus.RspValid !== 1'b0) begin
      errors++;
      $display("FAIL rsp_one_cycle: RspValid=%b one cycle later, expected 0", bus.RspValid);
    end
  endtask

  task automatic test_store_merge();
    logic [DATA_W-1:0] ed;
    logic              ef;
    send(1'b1, 2'd2, 1'b0, 7'h04, 32'hDEADBEEF);
    send(1'b1, 2'd0, 1'b0, 7'h05, 32'hFFFFFF12);
    send(1'b0, 2'd2, 1'b0, 7'h04, 32'h0);
    // drain the two store responses that were overwritten on the bus
    void'(exp_q.pop_front()); void'(exp_fault_q.pop_front());
    void'(exp_q.pop_front()); void'(exp_fault_q.pop_front());
    ed = exp_q.pop_front(); ef = exp_fault_q.pop_front();
    checks++;
    if (bus.RspValid !== 1'b1 || bus.RspData !== 32'hDEAD12EF || bus.RspFault !== 1'b0 || ed !== 32'hDEAD12EF || ef !== 1'b0) begin
      errors++;
      $display("FAIL store_merge: valid=%b data=%h fault=%b, expected valid=1 data=dead12ef fault=0",
               bus.RspValid, bus.RspData, bus.RspFault);
    end
  endtask

  task automatic test_sign_ext();
    logic [1:0]  sz  [3] = '{2'd0, 2'd0, 2'd1};
    logic        uns [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] lit [3] = '{32'hFFFFFF80, 32'h00000080, 32'h00000080};
    logic [DATA_W-1:0] ed;
    logic              ef;
    send(1'b1, 2'd0, 1'b0, 7'h08, 32'h00000080);
    void'(exp_q.pop_front()); void'(exp_fault_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      send(1'b0, sz[i], uns[i], 7'h08, 32'h0);
      ed = exp_q.pop_front(); ef = exp_fault_q.pop_front();
      checks++;
      if (bus.RspValid !== 1'b1 || bus.RspData !== lit[i] || bus.RspFault !== 1'b0 || ed !== lit[i] || ef !== 1'b0) begin
        errors++;
        $display("FAIL sign_ext[%0d]: valid=%b data=%h fault=%b, expected valid=1 data=%h fault=0",
                 i, bus.RspValid, bus.RspData, bus.RspFault, lit[i]);
      end
    end
  endtask

  task automatic test_faults();
    logic              w   [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0]        sz  [3] = '{2'd1, 2'd2, 2'd2};
    logic [6:0]        ad  [3] = '{7'h03, 7'h06, 7'h04};
    logic [DATA_W-1:0] ed;
    logic              ef;
    logic [31:0]       lit [3] = '{32'h0, 32'h0, 32'hDEAD12EF};
    logic              lf  [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      send(w[i], sz[i], 1'b0, ad[i], 32'h5555AAAA);
      ed = exp_q.pop_front(); ef = exp_fault_q.pop_front();
      checks++;
      if (bus.RspValid !== 1'b1 || bus.RspData !== lit[i] || bus.RspFault !== lf[i] || ed !== lit[i] || ef !== lf[i]) begin
        errors++;
        $display("FAIL fault[%0d]: valid=%b data=%h fault=%b, expected valid=1 data=%h fault=%b",
                 i, bus.RspValid, bus.RspData, bus.RspFault, lit[i], lf[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] ed;
    logic              ef;
    for (int n = 0; n < 300; n++) begin
      send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           7'($urandom_range(0, NB - 1)), $urandom);
      ed = exp_q.pop_front(); ef = exp_fault_q.pop_front();
      checks++;
      if (bus.RspValid !== 1'b1 || bus.RspData !== ed || bus.RspFault !== ef) begin
        errors++;
        $display("FAIL b2b[%0d]: valid=%b data=%h fault=%b, expected valid=1 data=%h fault=%b",
                 n, bus.RspValid, bus.RspData, bus.RspFault, ed, ef);
      end
      if ($urandom_range(0, 7) == 0) begin
        @(negedge Clock);
        checks++;
        if (bus.RspValid !== 1'b0) begin
          errors++;
          $display("FAIL idle_gap[%0d]: RspValid=%b, expected 0", n, bus.RspValid);
        end
      end
    end
  endtask

  task automatic test_clear_sweep();
    logic [DATA_W-1:0] ed;
    logic              ef;
    int                ready_low = 0;
    int                busy_cnt  = 0;
    send(1'b1, 2'd2, 1'b0, 7'h00, 32'hA5A5A5A5);
    void'(exp_q.pop_front()); void'(exp_fault_q.pop_front());
    // A load accepted on the edge before Clear is raised still responds.
    send(1'b0, 2'd2, 1'b0, 7'h00, 32'h0);
    bus.Clear = 1'b1;
    #1;
    ed = exp_q.pop_front(); ef = exp_fault_q.pop_front();
    checks++;
    if (bus.RspValid !== 1'b1 || bus.RspData !== ed || bus.RspFault !== ef || ed !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL pre_clear_rsp: valid=%b data=%h, expected valid=1 data=%h",
               bus.RspValid, bus.RspData, ed);
    end
    if (bus.ReqReady === 1'b0) ready_low++;
    @(posedge Clock);
    @(negedge Clock);
    bus.Clear = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      bus.Clear = (cyc == 10);
      #1;
      if (bus.ReqReady === 1'b1) break;
      ready_low++;
      if (bus.Busy === 1'b1) busy_cnt++;
      @(negedge Clock);
    end
    bus.Clear = 1'b0;
    checks++;
    if (busy_cnt != DEPTH) begin
      errors++;
      $display("FAIL busy_cycles: Busy high %0d cycles, expected %0d", busy_cnt, DEPTH);
    end
    checks++;
    if (ready_low != DEPTH + 1) begin
      errors++;
      $display("FAIL ready_low_cycles: ReqReady low %0d cycles, expected %0d", ready_low, DEPTH + 1);
    end
    checks++;
    if (bus.Busy !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL sweep_done: busy=%b state=%0d, expected busy=0 state=IDLE", bus.Busy, dbg_state);
    end
    for (int i = 0; i < NB; i++) ref_mem[i] = 8'h00;
    @(negedge Clock);
    for (int k = 0; k < 8; k++) begin
      send(1'b0, 2'd2, 1'b0, 7'(k * 4 * 4), 32'h0);
      ed = exp_q.pop_front(); ef = exp_fault_q.pop_front();
      checks++;
      if (bus.RspValid !== 1'b1 || bus.RspData !== ed || bus.RspFault !== ef || ed !== 32'h0) begin
        errors++;
        $display("FAIL cleared_load[%0d]: valid=%b data=%h, expected valid=1 data=00000000",
                 k, bus.RspValid, bus.RspData);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [DATA_W-1:0] ed;
    logic              ef;
    for (int k = 0; k < DEPTH; k++) begin
      send(1'b1, 2'd2, 1'b0, 7'(k * 4), $urandom | 32'h1);
      void'(exp_q.pop_front()); void'(exp_fault_q.pop_front());
    end
    bus.Clear = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    bus.Clear = 1'b0;
    repeat (4) @(negedge Clock);
    R = 1'b0;
    #1;
    checks++;
    if (bus.Busy !== 1'b0 || bus.RspValid !== 1'b0 || bus.RspData !== '0 || bus.RspFault !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_mid_sweep: busy=%b valid=%b data=%h fault=%b state=%0d, expected all 0 and IDLE",
               bus.Busy, bus.RspValid, bus.RspData, bus.RspFault, dbg_state);
    end
    @(negedge Clock);
    R = 1'b1;
    for (int i = 0; i < NB; i++) ref_mem[i] = 8'h00;
    #1;
    checks++;
    if (bus.ReqReady !== 1'b1 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: ready=%b busy=%b, expected ready=1 busy=0", bus.ReqReady, bus.Busy);
    end
    @(negedge Clock);
    for (int k = 0; k < DEPTH; k++) begin
      send(1'b0, 2'd2, 1'b0, 7'(k * 4), 32'h0);
      ed = exp_q.pop_front(); ef = exp_fault_q.pop_front();
      checks++;
      if (bus.RspValid !== 1'b1 || bus.RspData !== ed || bus.RspFault !== ef) begin
        errors++;
        $display("FAIL post_reset_load[%0d]: valid=%b data=%h fault=%b, expected valid=1 data=%h fault=%b",
                 k, bus.RspValid, bus.RspData, bus.RspFault, ed, ef);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < NB; i++) ref_mem[i] = 8'h00;
    bus.ReqValid    = 1'b0;
    bus.ReqWrite    = 1'b0;
    bus.ReqSize     = 2'd0;
    bus.ReqUnsigned = 1'b0;
    bus.ReqAddr     = '0;
    bus.ReqWData    = '0;
    bus.Clear       = 1'b0;

    test_reset();
    test_store_merge();
    test_sign_ext();
    test_faults();
    test_back_to_back();
    test_clear_sweep();
    test_reset_mid_sweep();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
